trap_ctrl: RTL and testbench

- Sequential exception controller directly downstream of the SYSCALL/BREAK decoder.
- Consumes is_syscall / is_break / trap_type from the execute-stage instruction. Records EPC, Cause and Status.EXL, flushes the pipeline, and redirects fetch to the handler vector.
- Handles ERET to return to EPC. Exposes CP0-style registers (Status 12, Cause 13, EPC 14) on a combinational read port for MFC0.

---
 rtl/trap_ctrl.sv | 153 +++++++++++++++
 tb/tb_trap_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// trap_ctrl: exception controller for SYSCALL/BREAK/ERET.
// On a trap it records EPC/Cause/EXL, flushes younger stages for one cycle,
// then redirects fetch to the handler. ERET flushes and returns to EPC.
// CP0 Status/Cause/EPC and the trap counter are readable combinationally.
module trap_ctrl #(
   parameter logic [31:0] HANDLER_BASE = 32'h0000_0180,
   parameter bit          EPC_PLUS4    = 1'b1,
   parameter int          CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ex_valid,
   input  logic             stall,
   input  logic             is_syscall,
   input  logic             is_break,
   input  logic [5:0]       trap_type,
   input  logic             is_eret,
   input  logic [31:0]      ex_pc,
   output logic             flush,
   output logic             redirect_valid,
   input  logic             redirect_ready,
   output logic [31:0]      redirect_pc,
   output logic             exl,
   input  logic [4:0]       cp0_raddr,
   output logic [31:0]      cp0_rdata,
   output logic [CNT_W-1:0] trap_count,
   output logic             type_mismatch
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FLUSH     = 3'd1,
      VECTOR    = 3'd2,
      HANDLER   = 3'd3,
      FLUSH_RET = 3'd4,
      RETURN    = 3'd5
   } state_t;

   localparam logic [4:0]       EXC_SYS  = 5'd8;
   localparam logic [4:0]       EXC_BRK  = 5'd9;
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [31:0]      EPC_OFFS = EPC_PLUS4 ? 32'd4 : 32'd0;

   state_t           state_q, state_d;
   logic [31:0]      epc_q, epc_d;
   logic [4:0]       code_q, code_d;
   logic             exl_q, exl_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mm_q, mm_d;

   logic             sample;
   logic             sample_st;
   logic             trap_acc;
   logic [4:0]       exc;

   // Decode sampling and trap acceptance; only IDLE and HANDLER look at the inputs
   always_comb begin
      sample    = ex_valid & ~stall;
      sample_st = (state_q == IDLE) || (state_q == HANDLER);
      trap_acc  = sample & sample_st & (is_syscall | is_break);
      exc       = is_syscall ? EXC_SYS : EXC_BRK;
   end

   // Next-state and architectural register update logic
   always_comb begin
      state_d = state_q;
      epc_d   = epc_q;
      code_d  = code_q;
      exl_d   = exl_q;
      cnt_d   = cnt_q;
      mm_d    = mm_q;

      unique case (state_q)
         IDLE: begin
            if (trap_acc) state_d = FLUSH;
         end
         FLUSH: begin
            state_d = VECTOR;
         end
         VECTOR: begin
            if (redirect_ready) state_d = HANDLER;
         end
         HANDLER: begin
            // trap flags take priority over a simultaneous ERET
            if (trap_acc) state_d = FLUSH;
            else if (sample && is_eret) state_d = FLUSH_RET;
         end
         FLUSH_RET: begin
            exl_d   = 1'b0;
            state_d = RETURN;
         end
         RETURN: begin
            if (redirect_ready) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (trap_acc) begin
         code_d = exc;
         // a nested trap keeps the original return address
         if (!exl_q) epc_d = ex_pc + EPC_OFFS;
         exl_d = 1'b1;
         if (cnt_q != CNT_MAX) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         if (trap_type != {1'b0, exc}) mm_d = 1'b1;
      end
   end

   // State and CP0 register storage with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         epc_q   <= '0;
         code_q  <= '0;
         exl_q   <= 1'b0;
         cnt_q   <= '0;
         mm_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         epc_q   <= epc_d;
         code_q  <= code_d;
         exl_q   <= exl_d;
         cnt_q   <= cnt_d;
         mm_q    <= mm_d;
      end
   end

   // Outputs decoded from state; EPC cannot change while RETURN is presenting it
   always_comb begin
      flush          = (state_q == FLUSH) || (state_q == FLUSH_RET);
      redirect_valid = (state_q == VECTOR) || (state_q == RETURN);
      redirect_pc    = '0;
      if (state_q == VECTOR) redirect_pc = HANDLER_BASE;
      else if (state_q == RETURN) redirect_pc = epc_q;
      exl            = exl_q;
      trap_count     = cnt_q;
      type_mismatch  = mm_q;
   end

   // CP0 read port for MFC0
   always_comb begin
      cp0_rdata = '0;
      case (cp0_raddr)
         5'd12:   cp0_rdata = {30'b0, exl_q, 1'b0};
         5'd13:   cp0_rdata = {25'b0, code_q, 2'b0};
         5'd14:   cp0_rdata = epc_q;
         5'd22:   cp0_rdata = 32'(cnt_q);
         default: cp0_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_trap_ctrl.sv
// Testbench for trap_ctrl: directed scenarios plus randomized traffic,
// compared cycle by cycle against a behavioural model of the controller.
module tb_trap_ctrl;

   localparam int          CNT_W = 4;
   localparam logic [31:0] BASE  = 32'h0000_0180;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             ex_valid, stall, is_syscall, is_break, is_eret;
   logic [5:0]       trap_type;
   logic [31:0]      ex_pc;
   logic             flush, redirect_valid, redirect_ready;
   logic [31:0]      redirect_pc;
   logic             exl;
   logic [4:0]       cp0_raddr;
   logic [31:0]      cp0_rdata;
   logic [CNT_W-1:0] trap_count;
   logic             type_mismatch;

   int n_chk = 0;
   int n_err = 0;

   trap_ctrl #(.HANDLER_BASE(BASE), .EPC_PLUS4(1'b1), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .stall(stall),
      .is_syscall(is_syscall), .is_break(is_break), .trap_type(trap_type),
      .is_eret(is_eret), .ex_pc(ex_pc), .flush(flush),
      .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
      .redirect_pc(redirect_pc), .exl(exl), .cp0_raddr(cp0_raddr),
      .cp0_rdata(cp0_rdata), .trap_count(trap_count),
      .type_mismatch(type_mismatch)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // Pending work is described as "one flush cycle owed" followed by
   // "a redirect to target owed until accepted".
   logic        m_flush_owed, m_redir_owed, m_is_return, m_in_handler;
   logic [31:0] m_target, m_epc;
   int          m_code, m_cnt;
   logic        m_exl, m_mm;

   task automatic m_reset();
      m_flush_owed = 0; m_redir_owed = 0; m_is_return = 0; m_in_handler = 0;
      m_target = 0; m_epc = 0; m_code = 0; m_cnt = 0; m_exl = 0; m_mm = 0;
   endtask

   // Advance the model by one clock using the inputs held across the edge
   task automatic m_edge();
      bit s;
      int c;
      s = ex_valid && !stall;
      if (m_flush_owed) begin
         m_flush_owed = 0;
         m_redir_owed = 1;
         if (m_is_return) m_exl = 0;
      end else if (m_redir_owed) begin
         if (redirect_ready) begin
            m_redir_owed = 0;
            m_in_handler = !m_is_return;
         end
      end else if (s && (is_syscall || is_break)) begin
         c = is_syscall ? 8 : 9;
         m_code = c;
         if (!m_exl) m_epc = ex_pc + 32'd4;
         m_exl = 1;
         if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
         if (int'(trap_type) != c) m_mm = 1;
         m_flush_owed = 1; m_is_return = 0; m_target = BASE;
      end else if (s && is_eret && m_in_handler) begin
         m_flush_owed = 1; m_is_return = 1; m_target = m_epc;
      end
   endtask

   function automatic logic [31:0] m_cp0(input logic [4:0] a);
      case (a)
         5'd12:   return m_exl ? 32'd2 : 32'd0;
         5'd13:   return 32'(m_code * 4);
         5'd14:   return m_epc;
         5'd22:   return 32'(m_cnt);
         default: return 32'd0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      check("flush", 32'(flush), 32'(m_flush_owed));
      check("rvalid", 32'(redirect_valid), 32'(m_redir_owed));
      check("rpc", redirect_pc, m_redir_owed ? m_target : 32'd0);
      check("exl", 32'(exl), 32'(m_exl));
      check("count", 32'(trap_count), 32'(m_cnt));
      check("mismatch", 32'(type_mismatch), 32'(m_mm));
      check("cp0", cp0_rdata, m_cp0(cp0_raddr));
   endtask

   // Drive one cycle of inputs at the falling edge, check, then clock the model
   task automatic step(input logic v, input logic st, input logic sc, input logic br,
                       input logic [5:0] tt, input logic er, input logic [31:0] pc,
                       input logic rdy, input logic [4:0] ra);
      @(negedge clk);
      ex_valid = v; stall = st; is_syscall = sc; is_break = br; trap_type = tt;
      is_eret = er; ex_pc = pc; redirect_ready = rdy; cp0_raddr = ra;
      #1;
      check_all();
      @(posedge clk);
      m_edge();
   endtask

   task automatic nop(input logic rdy, input logic [4:0] ra);
      step(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0000_1000, rdy, ra);
   endtask

   initial begin
      logic [5:0]  tt;
      logic [31:0] pc;
      logic [4:0]  ra;
      int          k;

      rst_n = 0; ex_valid = 0; stall = 0; is_syscall = 0; is_break = 0;
      trap_type = 0; is_eret = 0; ex_pc = 0; redirect_ready = 0; cp0_raddr = 0;
      m_reset();
      #12;
      check_all();
      @(negedge clk);
      rst_n = 1;

      // SYSCALL with ready high: flush next cycle, redirect the one after
      step(1, 0, 1, 0, 6'd8, 0, 32'h0040_0010, 1, 5'd14);
      #1 check("lat_flush", 32'(flush), 32'd1);
      nop(1, 5'd13);
      #1 check("lat_rv", 32'(redirect_valid), 32'd1);
      check("lat_rpc", redirect_pc, 32'h0000_0180);
      nop(1, 5'd14);
      #1 check("tp_epc", cp0_rdata, 32'h0040_0014);
      nop(1, 5'd13);
      #1 check("tp_cause", cp0_rdata, 32'h0000_0020);

      // ERET in HANDLER returns to EPC
      step(1, 0, 0, 0, 6'd0, 1, 32'h0000_0190, 1, 5'd12);
      nop(1, 5'd12);
      #1 check("ret_rpc", redirect_pc, 32'h0040_0014);
      nop(1, 5'd12);
      // ERET in IDLE: no effect
      step(1, 0, 0, 0, 6'd0, 1, 32'h0000_0300, 1, 5'd12);
      nop(1, 5'd12);
      nop(1, 5'd12);

      // BREAK with ready low for 3 cycles
      step(1, 0, 0, 1, 6'd9, 0, 32'h0040_0100, 0, 5'd13);
      nop(0, 5'd13);
      for (int i = 0; i < 3; i++) nop(0, 5'd13);
      #1 check("brk_held", redirect_pc, 32'h0000_0180);
      nop(1, 5'd13);
      #1 check("brk_cause", cp0_rdata, 32'h0000_0024);
      // nested SYSCALL inside HANDLER keeps EPC
      step(1, 0, 1, 0, 6'd8, 0, 32'h0000_0200, 1, 5'd14);
      for (int i = 0; i < 3; i++) nop(1, 5'd14);
      #1 check("nest_epc", cp0_rdata, 32'h0040_0104);
      // exit handler
      step(1, 0, 0, 0, 6'd0, 1, 32'h0, 1, 5'd22);
      for (int i = 0; i < 3; i++) nop(1, 5'd22);

      // ignored SYSCALLs, then trap_type disagreeing with the flag
      step(1, 1, 1, 0, 6'd8, 0, 32'h0000_0400, 1, 5'd22);
      step(0, 0, 1, 0, 6'd8, 0, 32'h0000_0400, 1, 5'd22);
      step(1, 0, 1, 0, 6'd0, 0, 32'h0000_0500, 1, 5'd13);
      #1 check("mm_set", 32'(type_mismatch), 32'd1);

      // reset asserted while in VECTOR
      nop(0, 5'd14);
      #2 rst_n = 0;
      #1;
      m_reset();
      check("rst_rv", 32'(redirect_valid), 32'd0);
      check("rst_fl", 32'(flush), 32'd0);
      check_all();
      @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 6; i++) nop($urandom_range(0, 1), 5'(12 + (i % 3)));

      // both flags + wraparound PC, then randomized traffic
      step(1, 0, 1, 1, 6'd9, 0, 32'hFFFF_FFFE, 1, 5'd14);
      for (int i = 0; i < 3; i++) nop(1, 5'd14);
      for (int n = 0; n < 4000; n++) begin
         k = $urandom_range(0, 3);
         tt = (k == 0) ? 6'd8 : (k == 1) ? 6'd9 : (k == 2) ? 6'd0 : 6'($urandom);
         pc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
         k = $urandom_range(0, 4);
         ra = (k == 0) ? 5'd12 : (k == 1) ? 5'd13 : (k == 2) ? 5'd14 : (k == 3) ? 5'd22 : 5'($urandom);
         step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, tt,
              $urandom_range(0, 2) == 0, pc, $urandom_range(0, 2) != 0, ra);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
